// File: rtl/commit_trace_fifo_if.sv
// Host-side trace drain bundle: head record fields plus valid/ready handshake.
// The FIFO drives the master side; the host/debug consumer uses the slave side.
interface commit_trace_fifo_if;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_seq;
  logic [31:0] trace_pc;
  logic [31:0] trace_inst;
  logic        trace_halt;
  logic        trace_reg_we;
  logic [4:0]  trace_reg_wa;
  logic [31:0] trace_reg_wd;
  logic        trace_dmem_we;
  logic [31:0] trace_dmem_wa;
  logic [31:0] trace_dmem_wd;

  modport master (
    output trace_valid, trace_seq, trace_pc, trace_inst, trace_halt,
           trace_reg_we, trace_reg_wa, trace_reg_wd,
           trace_dmem_we, trace_dmem_wa, trace_dmem_wd,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_seq, trace_pc, trace_inst, trace_halt,
           trace_reg_we, trace_reg_wa, trace_reg_wd,
           trace_dmem_we, trace_dmem_wa, trace_dmem_wd,
    output trace_ready
  );
endinterface

// File: rtl/commit_trace_fifo.sv
// Captures fresh commit events from the core, tags them with a sequence number and
// buffers them in a FIFO drained over a valid/ready handshake, with drop/halt status.
module commit_trace_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned PTR_W        = 4,
  parameter int unsigned STALL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  global_en,
  input  logic                  commit,
  input  logic [31:0]           commit_pc,
  input  logic [31:0]           commit_inst,
  input  logic                  commit_halt,
  input  logic                  commit_reg_we,
  input  logic [4:0]            commit_reg_wa,
  input  logic [31:0]           commit_reg_wd,
  input  logic                  commit_dmem_we,
  input  logic [31:0]           commit_dmem_wa,
  input  logic [31:0]           commit_dmem_wd,
  commit_trace_fifo_if.master   trace_if,
  output logic [PTR_W:0]        count,
  output logic                  stall_req,
  output logic                  overflow,
  output logic [15:0]           drop_cnt,
  output logic                  trace_done
);

  localparam logic [PTR_W:0] CntFull  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] StallThr = (PTR_W+1)'(DEPTH - STALL_MARGIN);

  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        halt;
    logic        reg_we;
    logic [4:0]  reg_wa;
    logic [31:0] reg_wd;
    logic        dmem_we;
    logic [31:0] dmem_wa;
    logic [31:0] dmem_wd;
  } rec_t;

  typedef enum logic [1:0] {StRun, StHaltSeen, StDone} state_e;

  state_e           state_q, state_d;
  logic             en_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      seq_q, seq_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  rec_t             mem_q [DEPTH];

  logic cap, pop, push, drop, full, valid;
  rec_t wr_rec, head_rec;

  // en_q aligns with the core's registered commit outputs, so a commit held while
  // global_en is low is not re-captured.
  assign cap   = commit && en_q && (state_q == StRun);
  assign full  = (count_q == CntFull);
  assign valid = (count_q != '0);
  assign pop   = valid && trace_if.trace_ready;
  assign push  = cap && (!full || pop);
  assign drop  = cap && full && !pop;

  always_comb begin
    wr_rec         = '0;
    wr_rec.seq     = seq_q;
    wr_rec.pc      = commit_pc;
    wr_rec.inst    = commit_inst;
    wr_rec.halt    = commit_halt;
    wr_rec.reg_we  = commit_reg_we;
    wr_rec.reg_wa  = commit_reg_wa;
    wr_rec.reg_wd  = commit_reg_wd;
    wr_rec.dmem_we = commit_dmem_we;
    wr_rec.dmem_wa = commit_dmem_wa;
    wr_rec.dmem_wd = commit_dmem_wd;
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    seq_d      = cap  ? seq_q + 32'd1   : seq_q;
    overflow_d = overflow_q || drop;
    drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    count_d    = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:      if (cap && commit_halt) state_d = StHaltSeen;
      StHaltSeen: if (count_q == '0 || (count_q == (PTR_W+1)'(1) && pop)) state_d = StDone;
      StDone:     state_d = StDone;
      default:    state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StRun;
      en_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= global_en;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: nothing is visible unless count says it is valid.
  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q] <= wr_rec;
  end

  assign head_rec = valid ? mem_q[rd_ptr_q] : '0;

  assign trace_if.trace_valid   = valid;
  assign trace_if.trace_seq     = head_rec.seq;
  assign trace_if.trace_pc      = head_rec.pc;
  assign trace_if.trace_inst    = head_rec.inst;
  assign trace_if.trace_halt    = head_rec.halt;
  assign trace_if.trace_reg_we  = head_rec.reg_we;
  assign trace_if.trace_reg_wa  = head_rec.reg_wa;
  assign trace_if.trace_reg_wd  = head_rec.reg_wd;
  assign trace_if.trace_dmem_we = head_rec.dmem_we;
  assign trace_if.trace_dmem_wa = head_rec.dmem_wa;
  assign trace_if.trace_dmem_wd = head_rec.dmem_wd;

  assign count      = count_q;
  assign stall_req  = (count_q >= StallThr);
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;
  assign trace_done = (state_q == StDone);

endmodule

// File: doc/commit_trace_fifo.md
Name: commit_trace_fifo

Overview:
- Sits directly downstream of the pipelined CPU core and consumes its registered commit_* debug outputs.
- Qualifies each retired instruction as a single fresh commit event and tags it with a sequence number.
- Buffers records in a DEPTH-entry FIFO and drains them to the host/debug side over a valid/ready handshake.
- Reports halt, overflow and drop status, and raises a back-pressure request so the system controller can deassert global_en before the FIFO fills.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 4
PTR_W, 4, log2(DEPTH)
STALL_MARGIN, 2, stall_req asserts when count >= DEPTH-STALL_MARGIN

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-low reset: sampled at posedge, rst==0 resets
global_en  in  1  same enable the CPU core uses
commit  in  1  core commit valid
commit_pc  in  32  retired PC
commit_inst  in  32  retired instruction
commit_halt  in  1  retired instruction is HALT (32'h80000000)
commit_reg_we  in  1  RF write enable
commit_reg_wa  in  5  RF write address
commit_reg_wd  in  32  RF write data
commit_dmem_we  in  1  data-memory write enable
commit_dmem_wa  in  32  data-memory address
commit_dmem_wd  in  32  data-memory write data
trace_valid  out  1  head record available
trace_ready  in  1  host accepts head record
trace_seq  out  32  head sequence number
trace_pc / trace_inst / trace_reg_wd / trace_dmem_wa / trace_dmem_wd  out  32 each  head record fields
trace_reg_we / trace_dmem_we / trace_halt  out  1 each  head record flags
trace_reg_wa  out  5  head record field
count  out  PTR_W+1  current occupancy, 0..DEPTH
stall_req  out  1  back-pressure request to the system controller
overflow  out  1  sticky: at least one record dropped
drop_cnt  out  16  saturating count of dropped records
trace_done  out  1  halt record captured and FIFO fully drained

Behaviour:
- Reset (rst==0 at posedge):
  - Pointers, count, en_q, seq counter, overflow, drop_cnt and FSM all clear; FSM returns to RUN.
  - All outputs 0; trace_* fields read 0 when empty.
  - Reset mid-stream discards all buffered records.
- Fresh-commit qualification:
  - en_q is a register that samples global_en every cycle.
  - A capture event (cap) is commit && en_q && state==RUN.
  - This prevents duplicate captures while the core's commit registers hold stale values with global_en low.
- Sequence counter:
  - 32-bit, starts at 0.
  - Increments on every cap, whether accepted or dropped, and wraps 0xFFFFFFFF -> 0.
  - An accepted record carries the counter's pre-increment value, so gaps in trace_seq expose drops.
- Push/pop:
  - pop = trace_valid && trace_ready.
  - push = cap && (count<DEPTH || pop).
  - Push and pop in the same cycle leave count unchanged, including at full.
  - Pointers wrap modulo DEPTH.
  - The write takes effect at the edge; a record pushed at edge k is visible on trace_* at k+1 (1-cycle latency when empty).
- Head output:
  - trace_* show the head entry combinationally from storage at the read pointer.
  - trace_valid = (count!=0).
  - Fields stay stable while trace_valid && !trace_ready.
- Drop:
  - A drop is cap && count==DEPTH && !pop.
  - The record is discarded and overflow sets (sticky until reset).
  - drop_cnt increments and saturates at 16'hFFFF.
- stall_req = (count >= DEPTH-STALL_MARGIN), combinational from count.
- FSM:
  - RUN: capture enabled. A cap with commit_halt==1 moves to HALT_SEEN. The halt record itself is pushed if space exists; if dropped, overflow still sets and the FSM still transitions.
  - HALT_SEEN: captures ignored and seq frozen; pops continue. Moves to DONE when count==0, or count==1 && pop.
  - DONE: trace_done=1. Held until reset; pops are irrelevant since the FIFO is empty.
- trace_halt carries the captured commit_halt bit of each record.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 two cycles with commit=1, global_en=1.
  - Response: count=0, trace_valid=0, overflow=0, seq=0; then release rst=1.
- Single commit:
  - Stimulus: global_en=1 steady, commit=1 for one cycle with pc=0x1C000000, inst=0x02A00093, reg_wa=1, reg_wd=42; trace_ready=1.
  - Response: trace_valid=1 for exactly one cycle with seq=0 and those fields; count returns to 0.
- Stale commit:
  - Stimulus: global_en drops to 0 while commit stays 1 for 5 cycles.
  - Response: exactly 1 record captured (the one before en fell), not 6.
- Fill and overflow (DEPTH=16):
  - Stimulus: trace_ready=0 and 18 consecutive commits.
  - Response: stall_req rises when count=14; count=16; overflow=1; drop_cnt=2; draining yields seq 0..15.
- Full plus simultaneous:
  - Stimulus: at count=16, trace_ready=1 and commit=1 in the same cycle.
  - Response: count stays 16, no drop, head advances; new tail has the next seq.
- Halt:
  - Stimulus: 3 records then inst=0x80000000 with commit_halt=1, followed by 2 more commits; drain with trace_ready=1.
  - Response: 4 records output, the last with trace_halt=1; the post-halt commits are ignored; trace_done=1 on the cycle after the final pop.
